mul_add_reconstruct: RTL and testbench

- Sequential unsigned shift-add unit that computes result = quation * b + remainder.
- It is the inverse of the team's combinational non_restoring_divide, which computes a / b -> quation, remainder. This block rebuilds the dividend from the divider's outputs.
- It also flags whether the triple (quation, remainder, b) is a correct division of a.
- It sits beside the divider as an in-system self-checker, and is also used as a standalone multiply-accumulate.

---
 rtl/mul_add_reconstruct.sv | 89 ++++++++
 tb/tb_mul_add_reconstruct.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mul_add_reconstruct.sv
// mul_add_reconstruct: sequential shift-add unit computing quation*b + remainder.
// It rebuilds a dividend from divider outputs and flags whether
// (quation, remainder, b) is a correct division of a. Latency is fixed at
// WIDTH RUN cycles, with no early exit.
module mul_add_reconstruct #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   quation,
   input  logic [WIDTH-1:0]   remainder,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               check_ok
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]         state;
   logic [WIDTH-1:0]   a_q;
   logic [2*WIDTH-1:0] mcand;     // b already shifted left by the bit counter
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [CW-1:0]      cnt;
   logic               rem_lt_b;
   logic               b_nz;

   // Conditional add of the shifted multiplicand for the current multiplier bit
   always_comb begin
      acc_next = acc;
      if (mplier[0]) acc_next = acc + mcand;
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         check_ok <= 1'b0;
         a_q      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
         rem_lt_b <= 1'b0;
         b_nz     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               a_q      <= a;
               mcand    <= {{WIDTH{1'b0}}, b};
               mplier   <= quation;
               acc      <= {{WIDTH{1'b0}}, remainder};
               cnt      <= '0;
               rem_lt_b <= (remainder < b);
               b_nz     <= (b != '0);
               busy     <= 1'b1;
               state    <= RUN;
            end
         end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            // The final iteration's sum goes straight to the result register
            if (cnt == LAST) begin
               state    <= IDLE;
               busy     <= 1'b0;
               done     <= 1'b1;
               result   <= acc_next;
               check_ok <= (acc_next == {{WIDTH{1'b0}}, a_q}) && rem_lt_b && b_nz;
            end
         end
      end
   end

endmodule

// File: tb/tb_mul_add_reconstruct.sv
// Scoreboard bench for mul_add_reconstruct: the driver pushes the expected
// response per accepted start and a monitor pops and compares on each done.
module tb_mul_add_reconstruct;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   a, b, quation, remainder;
   logic           busy, done, check_ok;
   logic [2*W-1:0] result;

   typedef struct {
      logic [2*W-1:0] res;
      logic           ok;
      int unsigned    dcyc;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;

   mul_add_reconstruct #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .quation(quation), .remainder(remainder), .busy(busy), .done(done),
      .result(result), .check_ok(check_ok)
   );

   always #5 clk = ~clk;

   // Edge counter
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: plain arithmetic on 2W-bit integers
   function automatic exp_t model(input logic [W-1:0] ma, mb, mq, mr);
      exp_t e;
      e.res  = 64'(mq) * 64'(mb) + 64'(mr);
      e.ok   = (e.res == 64'(ma)) && (mr < mb) && (mb != 0);
      e.dcyc = 0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no done (result=0x%0h)", result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("check_ok", 64'(check_ok), 64'(e.ok));
            chk("done_cycle", 64'(cyc), 64'(e.dcyc));
         end
      end
   end

   // Drive one start at the current negedge; inputs are scrambled afterwards
   task automatic issue(input logic [W-1:0] ia, ib, iq, ir);
      exp_t e;
      a = ia; b = ib; quation = iq; remainder = ir; start = 1'b1;
      e = model(ia, ib, iq, ir);
      e.dcyc = cyc + 1 + W;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; quation = $urandom; remainder = $urandom;
   endtask

   // Bounded wait for done, counting busy-high samples on the way
   task automatic wait_done(input int exp_busy);
      int n = 0;
      bit seen = 0;
      for (int k = 0; k < W + 8; k++) begin
         if (done === 1'b1) begin seen = 1; break; end
         if (busy === 1'b1) n++;
         @(negedge clk);
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", W + 8);
         sb.delete();
      end else begin
         chk("busy_cycles", 64'(n), 64'(exp_busy));
      end
   endtask

   task automatic run(input logic [W-1:0] ia, ib, iq, ir);
      issue(ia, ib, iq, ir);
      wait_done(W);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; quation = '0; remainder = '0;
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_result", result, 64'(0));
      chk("rst_check_ok", 64'(check_ok), 64'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run(32'd1, 32'd1, 32'd1, 32'd0);
      run(32'd8, 32'd3, 32'd2, 32'd2);
      run(32'd8, 32'd3, 32'd3, 32'd2);
      run(32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2);
      run(32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd3);
      run(32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(32'd5, 32'd0, 32'd7, 32'd5);
      run(32'd9, 32'd4, 32'd0, 32'd9);

      // Random: half are genuine divisions, half arbitrary
      for (int i = 0; i < 24; i++) begin
         logic [W-1:0] rb, rq, rr;
         if (i % 2 == 0) begin
            rb = $urandom_range(1, 65535);
            rq = $urandom_range(0, 65535);
            rr = $urandom % rb;
            run(rq * rb + rr, rb, rq, rr);
         end else begin
            run($urandom, $urandom, $urandom, $urandom);
         end
      end

      // Start coinciding with done is accepted; done still reports the old op
      issue(32'd15, 32'd4, 32'd3, 32'd3);
      wait_done(W);
      issue(32'd100, 32'd7, 32'd14, 32'd2);
      wait_done(W);

      // Start while busy is ignored
      issue(32'd50, 32'd6, 32'd8, 32'd2);
      repeat (9) @(negedge clk);
      a = 32'd1; b = 32'd1; quation = 32'd77; remainder = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(W - 10);
      repeat (W + 5) @(negedge clk);

      // Reset mid-operation aborts with no done
      issue(32'd21, 32'd5, 32'd4, 32'd1);
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_result", result, 64'(0));
      chk("abort_check_ok", 64'(check_ok), 64'(0));
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 5) @(negedge clk);

      // Operation after reset
      run(32'd1000, 32'd33, 32'd30, 32'd10);
      run($urandom, $urandom, $urandom, $urandom);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global safety bound
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
